// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types, RV32I constants and the JAL immediate decoder.
package if_pkg;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_e;

    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_unit_predecode.sv
// if_predecode: flags a JAL in the fetched word and computes its PC-relative target.
module if_predecode
    import if_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_is_jal,
    output logic [31:0] o_target
);

    assign o_is_jal = i_inst[6:0] == OPC_JAL;
    assign o_target = i_pc + jal_imm(i_inst);

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, single-outstanding imem fetch and IF/ID handshake.
// Defining FETCH_JAL_PREDICT_EN steers the next fetch to predecoded JAL targets.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [DATA_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] pcplus4_o,
    output logic [DATA_W-1:0] pcr_o
);

    if (DATA_W != 32) begin : g_bad_width
        $error("if_fetch_unit: DATA_W must be 32");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("if_fetch_unit: RESET_PC must be word aligned");
    end

    fetch_state_e      r_state, w_next_state;
    logic [DATA_W-1:0] r_pc, r_pc_out, r_inst, r_pcplus4, r_pcr;
    logic [DATA_W-1:0] w_pc4, w_next_pc;
    logic              r_valid, w_accept, w_resp;

    // Request is held off while reset is asserted so nothing escapes before release.
    assign imem_req_o  = reset_i && (r_state == S_REQ);
    assign imem_addr_o = r_pc;
    assign w_accept    = imem_req_o && imem_ready_i;
    assign w_resp      = (r_state == S_WAIT) && imem_rvalid_i;
    assign w_pc4       = r_pc + DATA_W'(4);

`ifdef FETCH_JAL_PREDICT_EN
    logic              w_is_jal;
    logic [DATA_W-1:0] w_jal_target;

    if_predecode u_predecode (
        .i_inst   (imem_rdata_i),
        .i_pc     (r_pc),
        .o_is_jal (w_is_jal),
        .o_target (w_jal_target)
    );

    assign w_next_pc = w_is_jal ? w_jal_target : w_pc4;
`else
    assign w_next_pc = w_pc4;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_state <= S_REQ;
        else
            r_state <= w_next_state;
    end

    // A redirect must still swallow any response that is already owed by memory.
    always_comb begin
        w_next_state = r_state;
        if (redirect_i)
            w_next_state = (w_accept || ((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid_i)) ? S_DROP : S_REQ;
        else
            case (r_state)
                S_REQ:   w_next_state = w_accept ? S_WAIT : S_REQ;
                S_WAIT:  w_next_state = imem_rvalid_i ? S_HOLD : S_WAIT;
                S_HOLD:  w_next_state = stall_i ? S_HOLD : S_REQ;
                S_DROP:  w_next_state = imem_rvalid_i ? S_REQ : S_DROP;
                default: w_next_state = S_REQ;
            endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_pc_out  <= '0;
            r_inst    <= '0;
            r_pcplus4 <= '0;
            r_pcr     <= '0;
        end else if (redirect_i) begin
            r_pc    <= redirect_pc_i & ~DATA_W'(3);
            r_valid <= 1'b0;
        end else if (w_resp) begin
            r_pc      <= w_next_pc;
            r_valid   <= 1'b1;
            r_pc_out  <= r_pc;
            r_inst    <= imem_rdata_i;
            r_pcplus4 <= w_pc4;
            r_pcr     <= w_next_pc;
        end else if (r_valid && !stall_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign pc_o      = r_pc_out;
    assign inst_o    = r_inst;
    assign pcplus4_o = r_pcplus4;
    assign pcr_o     = r_pcr;

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!reset_i)
        imem_rvalid_i |-> (r_state == S_WAIT || r_state == S_DROP));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized scoreboard bench for if_fetch_unit with an in-bench memory and fetch model.
module tb_if_fetch_unit;
    import if_pkg::*;

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0, reset_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
    logic        imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, pc_o, inst_o, pcplus4_o, pcr_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pcp4;
        logic [31:0] pcr;
    } deliv_t;

    deliv_t      q[$];
    deliv_t      last;
    int          n_vec = 0, n_err = 0, n_acc = 0;
    logic [31:0] exp_pc = '0, pend_addr = '0;
    logic        pend = 1'b0, stale = 1'b0, acc = 1'b0;
    int          cnt = 0, lat = 1, data_mode = 0;

    always #5 clk_i = ~clk_i;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .pcplus4_o     (pcplus4_o),
        .pcr_o         (pcr_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
        if (mode == 0) return RV32_NOP;
        if (mode == 2) return (a == 32'h100) ? RV32_NOP : 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[17:2]};
    endfunction

    // Architectural next PC: sequential, or the JAL target when prediction is built in.
    function automatic logic [31:0] next_of(input logic [31:0] pc, input logic [31:0] w);
        int off;
        off = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        return (JAL_EN && w[6:0] == 7'b1101111) ? pc + 32'(off) : pc + 32'd4;
    endfunction

    // One cycle of stimulus plus the memory and fetch-stream model for the coming edge.
    task automatic step(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
        logic [31:0] w;
        deliv_t d;
        @(negedge clk_i);
        imem_ready_i  = rdy;
        stall_i       = stl;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_rvalid_i = pend && cnt == 0;
        imem_rdata_i  = imem_rvalid_i ? mem_word(pend_addr, data_mode) : 32'h0;
        if (pend) chk("no_req_while_outstanding", 32'(imem_req_o), 32'd0);
        acc = imem_req_o && rdy;
        if (acc) begin
            n_acc++;
            chk("fetch_addr", imem_addr_o, exp_pc);
        end
        if (imem_rvalid_i) begin
            if (!stale && !rd) begin
                w = mem_word(exp_pc, data_mode);
                d.pc = exp_pc;
                d.inst = w;
                d.pcp4 = exp_pc + 32'd4;
                d.pcr = next_of(exp_pc, w);
                q.push_back(d);
                exp_pc = d.pcr;
            end
            pend = 1'b0;
        end else if (pend) begin
            cnt--;
            stale = stale || rd;
        end
        if (acc) begin
            pend = 1'b1;
            stale = rd;
            cnt = (lat == 0) ? $urandom_range(0, 2) : lat - 1;
            pend_addr = imem_addr_o;
        end
        if (rd) exp_pc = rpc & ~32'd3;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_ready_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_req", 32'(imem_req_o), 32'd0);
        chk("midrst_addr", imem_addr_o, 32'd0);
        chk("midrst_inst", inst_o, 32'd0);
        q.delete();
        pend = 1'b0;
        stale = 1'b0;
        exp_pc = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // Monitor: a delivery is due exactly when the model queued one; otherwise valid persists only under stall.
    initial begin : monitor
        logic ev;
        ev = 1'b0;
        last = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!reset_i) begin
                ev = 1'b0;
                last = '0;
            end else begin
                if (q.size() > 0) begin
                    last = q.pop_front();
                    ev = 1'b1;
                end else begin
                    ev = ev && stall_i && !redirect_i;
                end
                chk("valid_o", 32'(valid_o), 32'(ev));
                chk("pc_o", pc_o, last.pc);
                chk("inst_o", inst_o, last.inst);
                chk("pcplus4_o", pcplus4_o, last.pcp4);
                chk("pcr_o", pcr_o, last.pcr);
                if (valid_o) chk("no_req_in_hold", 32'(imem_req_o), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_pcplus4", pcplus4_o, 32'd0);
        chk("rst_pcr", pcr_o, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        chk("req_after_reset", 32'(imem_req_o), 32'd1);

        lat = 1;
        data_mode = 0;
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 20 && !valid_o; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_hold_reached", 32'(valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("stall_no_req", 32'(imem_req_o), 32'd0);
        end
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);

        lat = 3;
        data_mode = 2;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wait_accept_seen", 32'(acc), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h101);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_wait_addr", imem_addr_o, 32'h100);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);

        lat = 1;
        data_mode = 1;
        for (int i = 0; i < 20 && !valid_o; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_before_redir", 32'(valid_o), 32'd1);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_hold_addr", imem_addr_o, 32'h200);

        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_fetch_addr", imem_addr_o, 32'hFFFF_FFFC);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_next_addr", imem_addr_o, JAL_EN ? exp_pc : 32'h0);

        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom);
        end

        repeat (12) step(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk_i);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("progress", 32'(n_acc > 200), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage producer for the 5-stage RV32I pipeline. It owns the PC register, issues single-outstanding requests to instruction memory, and presents pc/inst/pcplus4/pcr to the IF/ID pipeline register with a valid/stall handshake. It honours redirects from branch/jump resolution and discards any in-flight fetch that a redirect makes stale.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
DATA_W, 32, instruction/address width; fixed at 32 and checked at elaboration.

Ports:
clk_i  in  1  clock; all state updates on posedge.
reset_i  in  1  asynchronous, active-low reset.
stall_i  in  1  downstream (IF/ID, hazard unit) not accepting; hold current outputs.
redirect_i  in  1  taken branch/jump or flush from EX; highest priority.
redirect_pc_i  in  32  new fetch PC; bits [1:0] are forced to 0 internally.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  32  fetch address (= pc_q).
imem_ready_i  in  1  memory accepts the request this cycle (req && ready = accept).
imem_rvalid_i  in  1  response data valid; at least 1 cycle after accept.
imem_rdata_i  in  32  fetched instruction word.
valid_o  out  1  pc_o/inst_o/pcplus4_o/pcr_o hold a live instruction.
pc_o  out  32  PC of the delivered instruction.
inst_o  out  32  delivered instruction word.
pcplus4_o  out  32  pc_o + 4.
pcr_o  out  32  next fetch PC chosen for this instruction.

Behaviour:
- Reset (async assert): state=S_REQ, pc_q=RESET_PC, drop_q=0, valid_o=0, pc_o=inst_o=pcplus4_o=pcr_o=0, imem_req_o=0. The first request is driven in the first cycle after reset deasserts.
- imem_req_o=1 only in S_REQ. imem_addr_o=pc_q at all times.
- S_REQ: when req && ready, go to S_WAIT.
- S_WAIT: when rvalid, register the outputs: pc_o=pc_q, inst_o=rdata, pcplus4_o=pc_q+4, pcr_o=next_pc, valid_o=1. Then pc_q=next_pc. Next state is S_HOLD.
- next_pc = pc_q+4 (see Optional Feature). All adds are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 = 0).
- S_HOLD: outputs are stable while stall_i=1. A cycle with valid_o && !stall_i is a consumption: next cycle valid_o=0 and state=S_REQ. Each instruction therefore takes at least 3 cycles with a 1-cycle memory.
- Redirect (any state, highest priority; overrides stall_i): pc_q=redirect_pc_i & ~3, valid_o=0 next cycle, data outputs keep their old values.
  - In S_WAIT with rvalid not in the same cycle: state=S_DROP.
  - In S_WAIT with rvalid in the same cycle: the response is discarded and state=S_REQ.
  - Otherwise: state=S_REQ.
  - In S_REQ with req && ready in the same cycle: the accepted request is outstanding, so state=S_DROP.
- S_DROP: discard the next rvalid, then go to S_REQ. A further redirect in S_DROP updates pc_q only and stays in S_DROP.
- rvalid outside S_WAIT/S_DROP is ignored and flagged by an assertion.
- Reset mid-operation: immediate return to the reset values. A response still in flight from before reset is the memory's responsibility and must not be delivered.

Optional Feature:
FETCH_JAL_PREDICT_EN.
- Defined: the response is predecoded in S_WAIT. If rdata[6:0]==7'b1101111 (JAL), next_pc = pc_q + sext({rdata[31],rdata[19:12],rdata[20],rdata[30:21],1'b0}), and pcr_o carries that target. EX must not redirect again for a predicted JAL.
- Undefined: next_pc = pc_q+4 always and pcr_o = pcplus4_o.

Decomposition:
- Package if_pkg: fetch_state_e enum (S_REQ, S_WAIT, S_HOLD, S_DROP), OPC_JAL constant, RV32 NOP 32'h0000_0013, and the function jal_imm(inst) returning a 32-bit sign-extended offset.
- Sub-module if_predecode: combinational, takes inst and pc and returns is_jal and target; instantiated only under FETCH_JAL_PREDICT_EN.

Test Plan:
- Reset release with memory ready=1 and 1-cycle rvalid returning 32'h0000_0013, stall_i=0 → imem_addr_o=0 then 4; valid_o pulses with pc_o=0, pcplus4_o=4, pcr_o=4.
- stall_i=1 for 5 cycles after delivery of pc 0x8 → outputs frozen and no imem_req_o; stall_i=0 → next request at 0xC.
- Redirect to 0x101 while in S_WAIT, with rvalid 2 cycles later carrying 32'hDEADBEEF → that word is never delivered; next request addr=0x100.
- Redirect while stall_i=1 in S_HOLD → valid_o=0 next cycle and next request at the redirect PC.
- RESET_PC=32'hFFFF_FFFC with one fetch → pcplus4_o=0 and the next request at 0x0.
- With FETCH_JAL_PREDICT_EN, inst 32'h0080006F at pc 0x20 → pcr_o=0x28 and the next request at 0x28. Without the macro → next request at 0x24.
